// File: rtl/bsg_thermometer_ramp.sv
// Thermometer ramp: walks a thermometer mask one bit per step toward a binary target.
// Latency: |target-cur|*(dwell_p+1) edges after acceptance; outputs are registered.
// Backpressure: ready_o is high only in IDLE; hold_i freezes stepping mid-ramp.
//
// Ports:
//   clk_i     - clock, all state updates on rising edge
//   reset_i   - asynchronous active-high reset
//   count_i   - requested target population (binary), sampled at transfer only
//   v_i       - count_i valid; transfer when v_i & ready_o at a rising edge
//   ready_o   - block is IDLE and can accept a new target
//   hold_i    - pause stepping (cur and dwell counter frozen) while high
//   thermo_o  - current mask, bits [cur-1:0] set
//   busy_o    - ramp in progress
//   done_o    - one-cycle pulse on the first IDLE cycle after reaching the target
//   count_o   - registered binary cur (only when BSG_THERMOMETER_RAMP_COUNT_O_EN is defined)
//
// Optional feature macro: BSG_THERMOMETER_RAMP_COUNT_O_EN adds the count_o telemetry port.

module bsg_thermometer_ramp #(
  parameter  int width_p     = 16,
  parameter  int dwell_p     = 0,
  localparam int lg_width_lp = $clog2(width_p+1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [lg_width_lp-1:0] count_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic                   hold_i,
  output logic [width_p-1:0]     thermo_o,
  output logic                   busy_o,
  output logic                   done_o
`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
  ,
  output logic [lg_width_lp-1:0] count_o
`endif
);

  // Dwell counter needs at least one bit even when dwell_p is 0.
  localparam int dwell_w_lp = (dwell_p < 1) ? 1 : $clog2(dwell_p+1);
  localparam logic [dwell_w_lp-1:0]  dwell_lp = dwell_w_lp'(dwell_p);
  localparam logic [lg_width_lp-1:0] width_lp = lg_width_lp'(width_p);

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] up_s   = 2'd1;
  localparam logic [1:0] down_s = 2'd2;

  logic [1:0]             state_r,  state_n;
  logic [lg_width_lp-1:0] cur_r,    cur_n;
  logic [lg_width_lp-1:0] target_r, target_n;
  logic [dwell_w_lp-1:0]  dwell_r,  dwell_n;
  logic                   done_r,   done_n;
  logic [width_p-1:0]     thermo_r, thermo_n;
  logic [lg_width_lp-1:0] target_clamped;

  // Requests beyond the bank count saturate so cur can never pass width_p.
  always_comb begin
    if (count_i > width_lp)
      target_clamped = width_lp;
    else
      target_clamped = count_i;
  end

  always_comb begin
    state_n  = state_r;
    cur_n    = cur_r;
    target_n = target_r;
    dwell_n  = dwell_r;
    done_n   = 1'b0;

    case (state_r)
      idle_s: begin
        if (v_i) begin
          target_n = target_clamped;
          if (target_clamped > cur_r) begin
            state_n = up_s;
            dwell_n = dwell_lp;
          end else if (target_clamped < cur_r) begin
            state_n = down_s;
            dwell_n = dwell_lp;
          end else begin
            // Already there: acknowledge with a done pulse, never go busy.
            done_n = 1'b1;
          end
        end
      end

      up_s, down_s: begin
        if (!hold_i) begin
          if (dwell_r == '0) begin
            // Target is strictly beyond cur in the ramp direction, so the
            // step can neither overflow width_p nor underflow zero.
            if (state_r == up_s)
              cur_n = cur_r + lg_width_lp'(1);
            else
              cur_n = cur_r - lg_width_lp'(1);
            dwell_n = dwell_lp;
            if (cur_n == target_r) begin
              state_n = idle_s;
              done_n  = 1'b1;
            end
          end else begin
            dwell_n = dwell_r - dwell_w_lp'(1);
          end
        end
      end

      default: begin
        state_n = idle_s;
      end
    endcase
  end

  // Mask is built from the next cur so the registered mask lines up with cur_r.
  always_comb begin
    thermo_n = '0;
    for (int i = 0; i < width_p; i++) begin
      thermo_n[i] = (cur_n > lg_width_lp'(i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= idle_s;
      cur_r    <= '0;
      target_r <= '0;
      dwell_r  <= '0;
      done_r   <= 1'b0;
      thermo_r <= '0;
    end else begin
      state_r  <= state_n;
      cur_r    <= cur_n;
      target_r <= target_n;
      dwell_r  <= dwell_n;
      done_r   <= done_n;
      thermo_r <= thermo_n;
    end
  end

  assign ready_o  = (state_r == idle_s);
  assign busy_o   = (state_r != idle_s);
  assign done_o   = done_r;
  assign thermo_o = thermo_r;

`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
  assign count_o = cur_r;
`endif

endmodule

// File: tb/tb_bsg_thermometer_ramp.sv
module tb_bsg_thermometer_ramp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: width 16, dwell 0
  logic [4:0]  c0;
  logic        v0, h0;
  logic        r0, b0, d0;
  logic [15:0] t0;
  // u2: width 16, dwell 2
  logic [4:0]  c2;
  logic        v2, h2;
  logic        r2, b2, d2;
  logic [15:0] t2;
  // u1: width 1, dwell 0
  logic [0:0]  c1;
  logic        v1, h1;
  logic        r1, b1, d1;
  logic [0:0]  t1;
`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
  logic [4:0]  n0, n2;
  logic [0:0]  n1;
`endif

  bsg_thermometer_ramp #(.width_p(16), .dwell_p(0)) u0 (
    .clk_i(clk), .reset_i(rst), .count_i(c0), .v_i(v0), .ready_o(r0),
    .hold_i(h0), .thermo_o(t0), .busy_o(b0), .done_o(d0)
`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
    , .count_o(n0)
`endif
  );

  bsg_thermometer_ramp #(.width_p(16), .dwell_p(2)) u2 (
    .clk_i(clk), .reset_i(rst), .count_i(c2), .v_i(v2), .ready_o(r2),
    .hold_i(h2), .thermo_o(t2), .busy_o(b2), .done_o(d2)
`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
    , .count_o(n2)
`endif
  );

  bsg_thermometer_ramp #(.width_p(1), .dwell_p(0)) u1 (
    .clk_i(clk), .reset_i(rst), .count_i(c1), .v_i(v1), .ready_o(r1),
    .hold_i(h1), .thermo_o(t1), .busy_o(b1), .done_o(d1)
`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
    , .count_o(n1)
`endif
  );

`ifdef BSG_THERMOMETER_RAMP_COUNT_O_EN
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(n0) !== $countones(t0) || int'(n2) !== $countones(t2) ||
          int'(n1) !== $countones(t1)) begin
        errors++;
        $display("FAIL count_o u0=%0d/%h u2=%0d/%h u1=%0d/%h", n0, t0, n2, t2, n1, t1);
      end
    end
  end
`endif

  function automatic logic [15:0] mask16(input int k);
    logic [16:0] one;
    one = 17'd1;
    return 16'((one << k) - 17'd1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    v0 = 0; h0 = 0; c0 = '0;
    v2 = 0; h2 = 0; c2 = '0;
    v1 = 0; h1 = 0; c1 = '0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (t0 !== 16'h0000) begin errors++; $display("FAIL reset_thermo got %h want 0000", t0); end
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", r0); end
    checks++; if (b0 !== 1'b0 || d0 !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", b0, d0); end
    rst = 1'b0;
    tick();
    checks++; if (t0 !== 16'h0000 || r0 !== 1'b1 || t2 !== 16'h0000 || t1 !== 1'b0) begin
      errors++; $display("FAIL post_reset got t0=%h r0=%b t2=%h t1=%b want 0000 1 0000 0", t0, r0, t2, t1);
    end
  endtask

  task automatic test_ramp_up;
    c0 = 5'd5; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    checks++; if (r0 !== 1'b0 || b0 !== 1'b1 || t0 !== 16'h0000) begin
      errors++; $display("FAIL up_accept got r=%b b=%b t=%h want 0 1 0000", r0, b0, t0);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (t0 !== mask16(k)) begin errors++; $display("FAIL up_thermo step%0d got %h want %h", k, t0, mask16(k)); end
      checks++; if (d0 !== (k == 5)) begin errors++; $display("FAIL up_done step%0d got %b want %b", k, d0, (k == 5)); end
    end
    checks++; if (r0 !== 1'b1 || b0 !== 1'b0) begin errors++; $display("FAIL up_idle got r=%b b=%b want 1 0", r0, b0); end
    tick();
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL up_done_once got %b want 0", d0); end
  endtask

  task automatic test_dwell_down;
    logic [15:0] exp;
    c2 = 5'd5; v2 = 1'b1;
    tick();
    v2 = 1'b0;
    for (int i = 0; i < 40 && d2 !== 1'b1; i++) tick();
    checks++; if (d2 !== 1'b1 || t2 !== 16'h001F) begin
      errors++; $display("FAIL dwell_up_timeout got d=%b t=%h want 1 001f", d2, t2);
    end
    // accepted in the same cycle done_o is high
    c2 = 5'd2; v2 = 1'b1;
    tick();
    v2 = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e < 3) ? 16'h001F : (e < 6) ? 16'h000F : (e < 9) ? 16'h0007 : 16'h0003;
      checks++; if (t2 !== exp) begin errors++; $display("FAIL dwell_thermo edge%0d got %h want %h", e, t2, exp); end
      checks++; if (d2 !== (e == 9)) begin errors++; $display("FAIL dwell_done edge%0d got %b want %b", e, d2, (e == 9)); end
    end
  endtask

  task automatic test_saturate;
    do_reset();
    c0 = 5'd20; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (t0 !== mask16(k)) begin errors++; $display("FAIL sat_thermo step%0d got %h want %h", k, t0, mask16(k)); end
      checks++; if (d0 !== (k == 16)) begin errors++; $display("FAIL sat_done step%0d got %b want %b", k, d0, (k == 16)); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (t0 !== 16'hFFFF || b0 !== 1'b0) begin errors++; $display("FAIL sat_hold got t=%h b=%b want ffff 0", t0, b0); end
    end
  endtask

  task automatic test_hold;
    do_reset();
    c0 = 5'd8; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (t0 !== mask16(k)) begin errors++; $display("FAIL hold_pre step%0d got %h want %h", k, t0, mask16(k)); end
    end
    h0 = 1'b1; v0 = 1'b1; c0 = 5'd2;
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (t0 !== 16'h0007 || r0 !== 1'b0 || b0 !== 1'b1) begin
        errors++; $display("FAIL hold_frozen cyc%0d got t=%h r=%b b=%b want 0007 0 1", j, t0, r0, b0);
      end
    end
    h0 = 1'b0; v0 = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++; if (t0 !== mask16(3 + j)) begin errors++; $display("FAIL hold_post step%0d got %h want %h", j, t0, mask16(3 + j)); end
      checks++; if (d0 !== (j == 5)) begin errors++; $display("FAIL hold_done step%0d got %b want %b", j, d0, (j == 5)); end
    end
    tick();
    checks++; if (t0 !== 16'h00FF || b0 !== 1'b0) begin errors++; $display("FAIL hold_final got t=%h b=%b want 00ff 0", t0, b0); end
  endtask

  task automatic test_equal;
    c0 = 5'd8; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    checks++; if (b0 !== 1'b0 || r0 !== 1'b1 || t0 !== 16'h00FF) begin
      errors++; $display("FAIL eq_state got b=%b r=%b t=%h want 0 1 00ff", b0, r0, t0);
    end
    checks++; if (d0 !== 1'b1) begin errors++; $display("FAIL eq_done got %b want 1", d0); end
    tick();
    checks++; if (d0 !== 1'b0 || t0 !== 16'h00FF || b0 !== 1'b0) begin
      errors++; $display("FAIL eq_after got d=%b t=%h b=%b want 0 00ff 0", d0, t0, b0);
    end
  endtask

  task automatic test_back_to_back;
    c0 = 5'd9; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    tick();
    checks++; if (t0 !== 16'h01FF || d0 !== 1'b1) begin errors++; $display("FAIL b2b_first got t=%h d=%b want 01ff 1", t0, d0); end
    c0 = 5'd7; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    checks++; if (r0 !== 1'b0 || b0 !== 1'b1 || d0 !== 1'b0 || t0 !== 16'h01FF) begin
      errors++; $display("FAIL b2b_accept got r=%b b=%b d=%b t=%h want 0 1 0 01ff", r0, b0, d0, t0);
    end
    tick();
    checks++; if (t0 !== 16'h00FF) begin errors++; $display("FAIL b2b_down1 got %h want 00ff", t0); end
    tick();
    checks++; if (t0 !== 16'h007F || d0 !== 1'b1) begin errors++; $display("FAIL b2b_down2 got t=%h d=%b want 007f 1", t0, d0); end
  endtask

  task automatic test_async_reset;
    logic seen_done;
    do_reset();
    c0 = 5'd10; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    checks++; if (t0 !== 16'h003F) begin errors++; $display("FAIL arst_pre got %h want 003f", t0); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (t0 !== 16'h0000 || r0 !== 1'b1 || b0 !== 1'b0 || d0 !== 1'b0) begin
      errors++; $display("FAIL arst_immediate got t=%h r=%b b=%b d=%b want 0000 1 0 0", t0, r0, b0, d0);
    end
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (d0 === 1'b1 || t0 !== 16'h0000) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL arst_quiet got activity=%b want 0", seen_done); end
  endtask

  task automatic test_width1;
    c1 = 1'b1; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    checks++; if (b1 !== 1'b1 || t1 !== 1'b0 || r1 !== 1'b0) begin
      errors++; $display("FAIL w1_accept got b=%b t=%b r=%b want 1 0 0", b1, t1, r1);
    end
    tick();
    checks++; if (t1 !== 1'b1 || d1 !== 1'b1) begin errors++; $display("FAIL w1_up got t=%b d=%b want 1 1", t1, d1); end
    c1 = 1'b0; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    checks++; if (t1 !== 1'b0 || d1 !== 1'b1 || r1 !== 1'b1) begin
      errors++; $display("FAIL w1_down got t=%b d=%b r=%b want 0 1 1", t1, d1, r1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_dwell_down();
    test_saturate();
    test_hold();
    test_equal();
    test_back_to_back();
    test_async_reset();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_thermometer_ramp.md
Name: bsg_thermometer_ramp

Overview:
- Inverse of the thermometer counter: accepts a binary count and drives a thermometer mask whose population equals that count.
- The mask moves one bit per step toward the target, never jumping. This gives slew-limited enabling and disabling of banked resources (power-gated SRAM banks, lane enables, credit masks).
- Sits between a control FSM issuing targets via valid/ready and the consumers of the per-bank enables.

Parameters:
- width_p, 16, number of thermometer bits (banks); must be >= 1.
- dwell_p, 0, extra idle cycles inserted between consecutive steps (step period = dwell_p+1 cycles).
- lg_width_lp, $clog2(width_p+1), derived local width of binary counts; not user-set.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- count_i  input  lg_width_lp  requested target population (binary).
- v_i  input  1  count_i valid.
- ready_o  output  1  block can accept a new target.
- hold_i  input  1  pause stepping while high.
- thermo_o  output  width_p  current mask; bits [cur-1:0] set, all others clear.
- busy_o  output  1  ramp in progress.
- done_o  output  1  one-cycle pulse when a ramp reaches its target.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- Reset values: thermo_o=0, cur=0, state=IDLE, ready_o=1, busy_o=0, done_o=0, dwell counter=0.
- Reset mid-ramp: mask clears to 0 immediately (asynchronously). No done_o is generated.
- Handshake:
  - ready_o=1 exactly when state==IDLE.
  - Transfer occurs on a rising edge with v_i & ready_o.
  - count_i is sampled only at transfer; the pending target cannot be changed mid-ramp.
- Saturation: count_i > width_p is clamped to width_p at acceptance.
- State IDLE:
  - On transfer with target==cur: remain IDLE, ready_o stays 1, done_o pulses next cycle.
  - On transfer with target>cur: go to UP.
  - On transfer with target<cur: go to DOWN.
  - The dwell counter loads dwell_p on entry to UP or DOWN.
- States UP and DOWN:
  - busy_o=1, ready_o=0.
  - Each cycle with hold_i=0: if the dwell counter is 0, step cur by +1 (UP) or -1 (DOWN) and reload dwell_p; otherwise decrement the counter.
  - hold_i=1 freezes both cur and the dwell counter.
  - When a step makes cur==target: next state IDLE, and done_o=1 for exactly the first cycle back in IDLE.
- Latency: with hold_i low, the mask reaches the target |target-cur|*(dwell_p+1) rising edges after the acceptance edge.
- Output timing: thermo_o is a registered function of cur; there are no combinational paths from inputs to outputs.
- Boundaries:
  - cur never exceeds width_p and never goes below 0; no wrap-around.
  - Target 0 from full ramps the mask down bit by bit, MSB first.
  - A new v_i asserted in the same cycle done_o is high is accepted, since ready_o=1 in IDLE.
  - Single-bit case (width_p=1) must work with lg_width_lp=1.

Optional Feature:
- Macro: BSG_THERMOMETER_RAMP_COUNT_O_EN.
- Defined: adds output count_o [lg_width_lp-1:0] carrying the registered binary cur, equal to popcount(thermo_o) every cycle, for telemetry.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset, then v_i=1, count_i=5, dwell_p=0 -> ready_o drops next cycle. thermo_o goes 0x0001, 0x0003, 0x0007, 0x000F, 0x001F on successive edges; done_o pulses once; ready_o returns to 1.
- From 0x001F, count_i=2, dwell_p=2 -> thermo_o goes 0x000F then 0x0007 then 0x0003, each held 3 cycles; total 9 edges after acceptance; single done_o.
- count_i=20 with width_p=16 -> saturates; final thermo_o=0xFFFF after 16 steps; cur never exceeds 16.
- Mid-ramp to 8, hold_i high for 4 cycles at cur=3 -> thermo_o stays 0x0007 for those 4 cycles; total latency extends by exactly 4; v_i asserted during busy is not accepted.
- count_i equal to current value (e.g. 0x00FF with count_i=8) -> no mask change; busy_o never asserts; done_o pulses one cycle later.
- Assert reset_i asynchronously mid-ramp at thermo_o=0x003F -> thermo_o=0 and ready_o=1 before the next clock edge; no done_o. With the macro defined, check count_o==popcount(thermo_o) every cycle throughout.
